// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one backing-memory port between the instruction-fetch requester
// (icache_*) and the data requester (dcache_*). Only one transaction is in
// flight at a time. dcache is preferred; a starvation counter forces an
// icache grant after STARVE_LIMIT consecutive dcache grants made while
// icache_req was pending.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   icache_req/addr        fetch request (level, held until icache_valid)
//   icache_data/valid      fetched word and one-cycle completion pulse
//   dcache_rreq/wreq       load / store requests (level, held until valid)
//   dcache_addr/wdata/byte_enable   load/store address, store data and lanes
//   dcache_rdata/rvalid    load data and one-cycle completion pulse
//   dcache_wvalid          one-cycle store completion pulse
//   mem_req/we/addr/wdata/be   registered memory request, held until accepted
//   mem_ready              memory accepts on mem_req && mem_ready at posedge
//   mem_rvalid/rdata       memory response pulse (reads and writes)
//
// state | meaning
// IDLE  | arbitrate; on grant latch owner and request fields
// ISSUE | mem_req high with latched fields until mem_ready
// WAIT  | request accepted, waiting for mem_rvalid
// RESP  | one-cycle valid pulse to the owner; no grant this cycle

module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                icache_req,
    input  logic [ADDR_W-1:0]   icache_addr,
    output logic [DATA_W-1:0]   icache_data,
    output logic                icache_valid,
    input  logic                dcache_rreq,
    input  logic                dcache_wreq,
    input  logic [ADDR_W-1:0]   dcache_addr,
    input  logic [DATA_W-1:0]   dcache_wdata,
    input  logic [DATA_W/8-1:0] dcache_byte_enable,
    output logic [DATA_W-1:0]   dcache_rdata,
    output logic                dcache_rvalid,
    output logic                dcache_wvalid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_I  = 2'd0,
        OWN_DR = 2'd1,
        OWN_DW = 2'd2
    } owner_t;

    state_t            state;
    state_t            state_next;
    owner_t            owner;
    owner_t            grant_owner;
    logic              grant;
    logic              capture;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_next;

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_owner = OWN_I;
        starve_next = starve_cnt;
        capture     = 1'b0;

        case (state)
            IDLE: begin
                // Starvation override beats the normal dcache-first order.
                if (icache_req && starve_cnt == CNT_MAX) begin
                    grant       = 1'b1;
                    grant_owner = OWN_I;
                end else if (dcache_wreq) begin
                    grant       = 1'b1;
                    grant_owner = OWN_DW;
                end else if (dcache_rreq) begin
                    grant       = 1'b1;
                    grant_owner = OWN_DR;
                end else if (icache_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_I;
                end

                if (grant) begin
                    state_next = ISSUE;
                    if (grant_owner == OWN_I) begin
                        starve_next = '0;
                    end else if (icache_req) begin
                        if (starve_cnt != CNT_MAX) begin
                            starve_next = starve_cnt + CNT_W'(1);
                        end
                    end else begin
                        starve_next = '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWN_I;
            starve_cnt    <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            icache_data   <= '0;
            icache_valid  <= 1'b0;
            dcache_rdata  <= '0;
            dcache_rvalid <= 1'b0;
            dcache_wvalid <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;

            if (grant) begin
                owner <= grant_owner;
                if (grant_owner == OWN_I) begin
                    mem_addr <= icache_addr;
                end else begin
                    mem_addr <= dcache_addr;
                end
                if (grant_owner == OWN_DW) begin
                    mem_we    <= 1'b1;
                    mem_wdata <= dcache_wdata;
                    mem_be    <= dcache_byte_enable;
                end else begin
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                    mem_be    <= {BE_W{1'b1}};
                end
            end

            mem_req <= (state_next == ISSUE);

            // Valids are high exactly in RESP, the cycle after capture.
            icache_valid  <= capture && (owner == OWN_I);
            dcache_rvalid <= capture && (owner == OWN_DR);
            dcache_wvalid <= capture && (owner == OWN_DW);

            if (capture) begin
                if (owner == OWN_I) begin
                    icache_data <= mem_rdata;
                end else if (owner == OWN_DR) begin
                    dcache_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_valid;
    logic        dcache_rreq;
    logic        dcache_wreq;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_byte_enable;
    logic [31:0] dcache_rdata;
    logic        dcache_rvalid;
    logic        dcache_wvalid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    // scoreboard: kind 0 = icache, 1 = dcache read, 2 = dcache write
    int          exp_kind[$];
    logic [31:0] exp_data[$];
    logic [32:0] acc_q[$];

    int          rv_cnt     = 0;
    int          resp_delay = 1;
    int          stall_left = 0;
    bit          noise      = 0;
    logic [31:0] rdata_next = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_data(icache_data), .icache_valid(icache_valid),
        .dcache_rreq(dcache_rreq), .dcache_wreq(dcache_wreq),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .dcache_byte_enable(dcache_byte_enable),
        .dcache_rdata(dcache_rdata), .dcache_rvalid(dcache_rvalid),
        .dcache_wvalid(dcache_wvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory model: everything driven on the falling edge.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata_next;
            end
        end else if (noise && $urandom_range(0, 1) == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
        end
        if (mem_req && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
        if (mem_req && mem_ready && !rst) begin
            acc_q.push_back({mem_we, mem_addr});
            rv_cnt     = resp_delay;
            rdata_next = mem_we ? $urandom : mem_val(mem_addr);
        end
    end

    // Response monitor: pops the scoreboard on every valid pulse.
    always @(negedge clk) begin
        if (!rst) begin
            automatic int nv = int'(icache_valid) + int'(dcache_rvalid) + int'(dcache_wvalid);
            automatic int kind;
            automatic int ek;
            automatic logic [31:0] dat;
            automatic logic [31:0] ed;
            if (nv > 1) begin
                checks++;
                failures++;
                $display("FAIL multi_valid: %0d valids in one cycle, required at most 1", nv);
            end else if (nv == 1) begin
                kind = icache_valid ? 0 : (dcache_rvalid ? 1 : 2);
                dat  = icache_valid ? icache_data : dcache_rdata;
                checks++;
                if (exp_kind.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid: kind %0d pulsed, required no pulse", kind);
                end else begin
                    ek = exp_kind.pop_front();
                    ed = exp_data.pop_front();
                    if (kind !== ek) begin
                        failures++;
                        $display("FAIL resp_kind: got %0d, required %0d", kind, ek);
                    end else if (kind != 2 && dat !== ed) begin
                        failures++;
                        $display("FAIL resp_data: got %h, required %h", dat, ed);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, icache_data, icache_valid,
             dcache_rdata, dcache_rvalid, dcache_wvalid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: mem_req=%b mem_addr=%h icache_data=%h, required all 0",
                     mem_req, mem_addr, icache_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== 2'd0 || dut.starve_cnt !== '0) begin
            failures++;
            $display("FAIL reset_state: state=%0d starve=%0d, required 0/0", dut.state, dut.starve_cnt);
        end
    endtask

    task automatic test_single_fetch();
        resp_delay  = 1;
        icache_addr = 32'h100;
        icache_req  = 1'b1;
        exp_kind.push_back(0);
        exp_data.push_back(32'h0000_0013);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            failures++;
            $display("FAIL fetch_c1: req=%b we=%b be=%h addr=%h, required 1 0 f 00000100",
                     mem_req, mem_we, mem_be, mem_addr);
        end
        @(negedge clk);
        checks++;
        if ({mem_req, icache_valid} !== 2'b00) begin
            failures++;
            $display("FAIL fetch_c2: req=%b valid=%b, required 0 0", mem_req, icache_valid);
        end
        @(negedge clk);
        checks++;
        if (icache_valid !== 1'b1 || icache_data !== 32'h13) begin
            failures++;
            $display("FAIL fetch_c3: valid=%b data=%h, required 1 00000013", icache_valid, icache_data);
        end
        icache_req = 1'b0;
        @(negedge clk);
        checks++;
        if (icache_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_c4: valid=%b, required 0", icache_valid);
        end
    endtask

    task automatic test_store_backpressure();
        int req_cycles = 0;
        int wv = 0;
        int other = 0;
        int done_at = -1;
        stall_left         = 3;
        dcache_addr        = 32'h2004;
        dcache_wdata       = 32'hDEAD_BEEF;
        dcache_byte_enable = 4'h3;
        dcache_wreq        = 1'b1;
        exp_kind.push_back(2);
        exp_data.push_back('0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) begin
                req_cycles++;
                checks++;
                if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h2004, 32'hDEAD_BEEF, 4'h3}) begin
                    failures++;
                    $display("FAIL store_fields: we=%b addr=%h wdata=%h be=%h, required 1 00002004 deadbeef 3",
                             mem_we, mem_addr, mem_wdata, mem_be);
                end
            end
            if (dcache_wvalid) begin
                wv++;
                dcache_wreq = 1'b0;
                done_at = i;
            end
            if (dcache_rvalid || icache_valid) other++;
            if (done_at >= 0 && i >= done_at + 3) break;
        end
        checks++;
        if (req_cycles != 4) begin
            failures++;
            $display("FAIL store_req_cycles: got %0d, required 4", req_cycles);
        end
        checks++;
        if (wv != 1 || other != 0) begin
            failures++;
            $display("FAIL store_pulses: wvalid=%0d other=%0d, required 1 0", wv, other);
        end
        dcache_wreq = 1'b0;
    endtask

    task automatic test_simultaneous();
        int w_at = -1;
        int r_at = -1;
        acc_q.delete();
        dcache_addr        = 32'h3000;
        dcache_wdata       = 32'h1234_5678;
        dcache_byte_enable = 4'hF;
        dcache_wreq        = 1'b1;
        dcache_rreq        = 1'b1;
        exp_kind.push_back(2);
        exp_data.push_back('0);
        exp_kind.push_back(1);
        exp_data.push_back(mem_val(32'h3000));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dcache_wvalid) begin
                w_at = i;
                dcache_wreq = 1'b0;
            end
            if (dcache_rvalid) begin
                r_at = i;
                dcache_rreq = 1'b0;
            end
            if (w_at >= 0 && r_at >= 0) break;
        end
        checks++;
        if (w_at < 0 || r_at < 0 || w_at >= r_at) begin
            failures++;
            $display("FAIL simul_order: wvalid at %0d rvalid at %0d, required write before read", w_at, r_at);
        end
        checks++;
        if (acc_q.size() != 2 || acc_q[0][32] !== 1'b1 || acc_q[1][32] !== 1'b0) begin
            failures++;
            $display("FAIL simul_grants: %0d accepts, required write then read", acc_q.size());
        end
        dcache_wreq = 1'b0;
        dcache_rreq = 1'b0;
    endtask

    task automatic test_contention();
        int nval = 0;
        logic [32:0] exp_acc;
        acc_q.delete();
        icache_addr = 32'h200;
        dcache_addr = 32'h4000;
        icache_req  = 1'b1;
        dcache_rreq = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) begin
                exp_kind.push_back(0);
                exp_data.push_back(mem_val(32'h200));
            end else begin
                exp_kind.push_back(1);
                exp_data.push_back(mem_val(32'h4000));
            end
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (icache_valid || dcache_rvalid) nval++;
            if (icache_valid) begin
                checks++;
                if (dut.starve_cnt !== '0) begin
                    failures++;
                    $display("FAIL starve_clear: starve_cnt=%0d after icache grant, required 0", dut.starve_cnt);
                end
            end
            if (nval == 10) begin
                icache_req  = 1'b0;
                dcache_rreq = 1'b0;
                break;
            end
        end
        icache_req  = 1'b0;
        dcache_rreq = 1'b0;
        checks++;
        if (nval != 10 || acc_q.size() != 10) begin
            failures++;
            $display("FAIL contention_count: valids=%0d accepts=%0d, required 10 10", nval, acc_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                exp_acc = (k % 5 == 4) ? {1'b0, 32'h200} : {1'b0, 32'h4000};
                checks++;
                if (acc_q[k] !== exp_acc) begin
                    failures++;
                    $display("FAIL contention_grant%0d: got %h, required %h", k, acc_q[k], exp_acc);
                end
            end
        end
    endtask

    task automatic test_idle();
        int bad_req = 0;
        int pulses = 0;
        noise = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0) bad_req++;
            if (icache_valid || dcache_rvalid || dcache_wvalid) pulses++;
        end
        noise = 0;
        @(negedge clk);
        checks++;
        if (bad_req != 0 || pulses != 0) begin
            failures++;
            $display("FAIL idle_quiet: mem_req cycles=%0d pulses=%0d, required 0 0", bad_req, pulses);
        end
        checks++;
        if (icache_data !== mem_val(32'h200) || dcache_rdata !== mem_val(32'h4000)) begin
            failures++;
            $display("FAIL idle_hold: icache_data=%h dcache_rdata=%h, required %h %h",
                     icache_data, dcache_rdata, mem_val(32'h200), mem_val(32'h4000));
        end
    endtask

    task automatic test_reset_in_wait();
        int pulses = 0;
        bit late_seen = 0;
        resp_delay  = 8;
        dcache_addr = 32'h5000;
        dcache_rreq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dut.state !== 2'd2) begin
            failures++;
            $display("FAIL rst_wait_setup: state=%0d, required 2", dut.state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, icache_data, icache_valid,
             dcache_rdata, dcache_rvalid, dcache_wvalid} !== '0) begin
            failures++;
            $display("FAIL rst_wait_outputs: mem_addr=%h icache_data=%h dcache_rdata=%h, required all 0",
                     mem_addr, icache_data, dcache_rdata);
        end
        dcache_rreq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_rvalid) late_seen = 1;
            if (icache_valid || dcache_rvalid || dcache_wvalid) pulses++;
        end
        checks++;
        if (pulses != 0 || !late_seen) begin
            failures++;
            $display("FAIL rst_wait_pulses: pulses=%0d late_rvalid=%0d, required 0 1", pulses, late_seen);
        end
        checks++;
        if (dut.state !== 2'd0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_idle: state=%0d mem_req=%b, required 0 0", dut.state, mem_req);
        end
        resp_delay = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        icache_req         = 1'b0;
        icache_addr        = '0;
        dcache_rreq        = 1'b0;
        dcache_wreq        = 1'b0;
        dcache_addr        = '0;
        dcache_wdata       = '0;
        dcache_byte_enable = '0;
        mem_ready          = 1'b1;
        mem_rvalid         = 1'b0;
        mem_rdata          = '0;

        test_reset();
        test_single_fetch();
        test_store_backpressure();
        test_simultaneous();
        test_contention();
        test_idle();
        test_reset_in_wait();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_kind.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d responses missing, required 0", exp_kind.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
